// File: rtl/alu_pkg.sv
// Shared ALU types and constants for the multiplier arbiter.
// Holds the arbiter FSM encoding, operand width and the quiet-NaN pattern.
package alu_pkg;

  localparam int OPND_W = 32;
  localparam logic [OPND_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/mul_unit_arbiter_if.sv
// Requester and MultiUnit bundle around the arbiter; master is the arbiter side.
// req_err exists only when MUL_ARB_TIMEOUT_EN is defined.
interface mul_unit_arbiter_if import alu_pkg::*; #(
  parameter int NUM_REQ = 3
);

  logic [NUM_REQ-1:0]        req_trig;
  logic [NUM_REQ*OPND_W-1:0] req_data1;
  logic [NUM_REQ*OPND_W-1:0] req_data2;
  logic [OPND_W-1:0]         req_result;
  logic [NUM_REQ-1:0]        req_vld;
  logic [NUM_REQ-1:0]        req_busy;
  logic [OPND_W-1:0]         mul_data1_out;
  logic [OPND_W-1:0]         mul_data2_out;
  logic                      mul_trig_out;
  logic [OPND_W-1:0]         mul_result_in;
  logic                      mul_result_vld;
`ifdef MUL_ARB_TIMEOUT_EN
  logic [NUM_REQ-1:0]        req_err;

  modport master (
    input  req_trig, req_data1, req_data2, mul_result_in, mul_result_vld,
    output req_result, req_vld, req_busy, mul_data1_out, mul_data2_out, mul_trig_out, req_err
  );
  modport slave (
    output req_trig, req_data1, req_data2, mul_result_in, mul_result_vld,
    input  req_result, req_vld, req_busy, mul_data1_out, mul_data2_out, mul_trig_out, req_err
  );
`else
  modport master (
    input  req_trig, req_data1, req_data2, mul_result_in, mul_result_vld,
    output req_result, req_vld, req_busy, mul_data1_out, mul_data2_out, mul_trig_out
  );
  modport slave (
    output req_trig, req_data1, req_data2, mul_result_in, mul_result_vld,
    input  req_result, req_vld, req_busy, mul_data1_out, mul_data2_out, mul_trig_out
  );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first pending bit after last_grant, wrapping; purely combinational.
// any_vld is low when nothing is pending.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int GRANT_W = 2
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] next_grant,
  output logic               any_vld
);

  logic [GRANT_W-1:0] cand;

  always_comb begin
    next_grant = '0;
    any_vld    = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GRANT_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_vld && pending[cand]) begin
        any_vld    = 1'b1;
        next_grant = cand;
      end
    end
  end

endmodule

// File: rtl/mul_unit_arbiter.sv
// Shares one MultiUnit among NUM_REQ one-shot requesters, round-robin; trig->mul_trig 2 edges, result->req_vld 1 edge.
// Trigs from a busy requester are dropped; MUL_ARB_TIMEOUT_EN adds a WAIT watchdog returning qNaN with req_err.
module mul_unit_arbiter import alu_pkg::*; #(
  parameter int NUM_REQ = 3
`ifdef MUL_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  mul_unit_arbiter_if.master  bus
);

  localparam int GRANT_W = $clog2(NUM_REQ);

  state_t                            state_q, state_d;
  logic [GRANT_W-1:0]                grant_q, grant_d;
  logic [GRANT_W-1:0]                last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]                pending_q, pending_d;
  logic [NUM_REQ-1:0][OPND_W-1:0]    slot1_q, slot1_d, slot2_q, slot2_d;
  logic [OPND_W-1:0]                 mul_d1_q, mul_d1_d, mul_d2_q, mul_d2_d;
  logic                              mul_trig_q, mul_trig_d;
  logic [OPND_W-1:0]                 result_q, result_d;
  logic [NUM_REQ-1:0]                vld_q, vld_d;
  logic [GRANT_W-1:0]                arb_grant;
  logic                              arb_vld;
  logic                              rsp_done, tmo_hit, finish;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .GRANT_W(GRANT_W)) u_rr (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .next_grant (arb_grant),
    .any_vld    (arb_vld)
  );

  assign rsp_done = (state_q == WAIT) && bus.mul_result_vld;

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  // A real result on the final watchdog cycle wins over the timeout.
  assign tmo_hit = (state_q == WAIT) && !bus.mul_result_vld &&
                   (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign bus.req_err = err_q;
`else
  assign tmo_hit = 1'b0;
`endif

  assign finish = rsp_done | tmo_hit;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE:    if (arb_vld) begin
                 grant_d = arb_grant;
                 state_d = ISSUE;
               end
      ISSUE:   state_d = WAIT;
      WAIT:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d    = pending_q;
    slot1_d      = slot1_q;
    slot2_d      = slot2_q;
    mul_d1_d     = mul_d1_q;
    mul_d2_d     = mul_d2_q;
    mul_trig_d   = 1'b0;
    result_d     = result_q;
    vld_d        = '0;
    last_grant_d = last_grant_q;
`ifdef MUL_ARB_TIMEOUT_EN
    err_d = '0;
    cnt_d = (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
`endif
    // Capture checks the pre-edge pending bit, so a trig on the completing edge is lost.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_trig[i] && !pending_q[i]) begin
        pending_d[i] = 1'b1;
        slot1_d[i]   = bus.req_data1[OPND_W*i +: OPND_W];
        slot2_d[i]   = bus.req_data2[OPND_W*i +: OPND_W];
      end
    end
    if (state_q == ISSUE) begin
      mul_d1_d   = slot1_q[grant_q];
      mul_d2_d   = slot2_q[grant_q];
      mul_trig_d = 1'b1;
    end
    if (finish) begin
      pending_d[grant_q] = 1'b0;
      vld_d[grant_q]     = 1'b1;
      last_grant_d       = grant_q;
      result_d           = rsp_done ? bus.mul_result_in : FP_QNAN;
`ifdef MUL_ARB_TIMEOUT_EN
      err_d[grant_q]     = tmo_hit;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      grant_q      <= '0;
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
      pending_q    <= '0;
      slot1_q      <= '0;
      slot2_q      <= '0;
      mul_d1_q     <= '0;
      mul_d2_q     <= '0;
      mul_trig_q   <= 1'b0;
      result_q     <= '0;
      vld_q        <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      slot1_q      <= slot1_d;
      slot2_q      <= slot2_d;
      mul_d1_q     <= mul_d1_d;
      mul_d2_q     <= mul_d2_d;
      mul_trig_q   <= mul_trig_d;
      result_q     <= result_d;
      vld_q        <= vld_d;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign bus.req_result    = result_q;
  assign bus.req_vld       = vld_q;
  assign bus.req_busy      = pending_q;
  assign bus.mul_data1_out = mul_d1_q;
  assign bus.mul_data2_out = mul_d2_q;
  assign bus.mul_trig_out  = mul_trig_q;

endmodule

// File: tb/tb_mul_unit_arbiter.sv
// Bench for mul_unit_arbiter: transaction model checked every cycle plus directed literal checks.
// A small MultiUnit stand-in answers each mul_trig_out three cycles later.
module tb_mul_unit_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 3;
  localparam int TMO  = 8;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   ecnt  = 0;

  always #5 sys_clk = ~sys_clk;

  mul_unit_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  mul_unit_arbiter #(
    .NUM_REQ(NREQ)
`ifdef MUL_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- MultiUnit stand-in ----------------
  logic        mu_vld  = 1'b0;
  logic [31:0] mu_res  = '0;
  logic [31:0] mu_a    = '0;
  logic [31:0] mu_b    = '0;
  int          mu_cnt  = 0;
  bit          mu_en   = 1'b1;
  logic        inj_vld = 1'b0;
  logic [31:0] inj_res = '0;

  assign bus.mul_result_vld = mu_vld | inj_vld;
  assign bus.mul_result_in  = inj_vld ? inj_res : mu_res;

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3FC00000, 32'h40000000}: return 32'h40400000;  // 1.5*2 = 3
      {32'h40000000, 32'h40400000}: return 32'h40C00000;  // 2*3 = 6
      {32'h3F800000, 32'h40800000}: return 32'h40800000;  // 1*4 = 4
      {32'h40400000, 32'h40400000}: return 32'h41100000;  // 3*3 = 9
      default:                      return a ^ b;
    endcase
  endfunction

  always @(negedge sys_clk) begin
    mu_vld = 1'b0;
    if (mu_cnt > 0) begin
      mu_cnt--;
      if (mu_cnt == 0) begin
        mu_vld = 1'b1;
        mu_res = fmul(mu_a, mu_b);
      end
    end
    if (bus.mul_trig_out && mu_en) begin
      mu_a   = bus.mul_data1_out;
      mu_b   = bus.mul_data2_out;
      mu_cnt = 3;
    end
  end

  // ---------------- model + per-cycle compare ----------------
  logic [NREQ-1:0] mpend = '0, opend, e_vld = '0, e_err = '0;
  logic [31:0]     mop1 [NREQ];
  logic [31:0]     mop2 [NREQ];
  logic [31:0]     e_res = '0, e_d1 = '0, e_d2 = '0;
  logic            e_trig = 1'b0;
  int              mlast = NREQ - 1, mcur = -1, mwcnt = 0, mj;
  bit              mwait = 1'b0;

  int              vld_who [$];
  int              vld_edge[$];
  logic [31:0]     vld_res [$];
  logic [NREQ-1:0] err_log [$];
  int              trg_edge[$];
  logic [31:0]     trg_d1  [$];
  logic [31:0]     trg_d2  [$];

  always @(posedge sys_clk) begin
    #1;
    ecnt++;
    if (!sys_rst_n) begin
      mpend = '0; mcur = -1; mlast = NREQ - 1; mwait = 1'b0; mwcnt = 0;
      e_res = '0; e_d1 = '0; e_d2 = '0; e_vld = '0; e_err = '0; e_trig = 1'b0;
    end else begin
      opend  = mpend;
      e_vld  = '0;
      e_err  = '0;
      e_trig = 1'b0;
      if (mcur >= 0 && mwait) begin
        if (bus.mul_result_vld) begin
          e_vld[mcur] = 1'b1; e_res = bus.mul_result_in;
          mpend[mcur] = 1'b0; mlast = mcur; mcur = -1;
        end else begin
          mwcnt++;
`ifdef MUL_ARB_TIMEOUT_EN
          if (mwcnt == TMO) begin
            e_vld[mcur] = 1'b1; e_err[mcur] = 1'b1; e_res = FP_QNAN;
            mpend[mcur] = 1'b0; mlast = mcur; mcur = -1;
          end
`endif
        end
      end else if (mcur >= 0) begin
        e_trig = 1'b1; e_d1 = mop1[mcur]; e_d2 = mop2[mcur];
        mwait  = 1'b1; mwcnt = 0;
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          mj = (mlast + k) % NREQ;
          if (mcur < 0 && opend[mj]) begin
            mcur  = mj;
            mwait = 1'b0;
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_trig[i] && !opend[i]) begin
          mpend[i] = 1'b1;
          mop1[i]  = bus.req_data1[32*i +: 32];
          mop2[i]  = bus.req_data2[32*i +: 32];
        end
      end
    end
    chk("cyc_busy",   32'(bus.req_busy),     32'(mpend));
    chk("cyc_vld",    32'(bus.req_vld),      32'(e_vld));
    chk("cyc_result", bus.req_result,        e_res);
    chk("cyc_trig",   32'(bus.mul_trig_out), 32'(e_trig));
    chk("cyc_d1",     bus.mul_data1_out,     e_d1);
    chk("cyc_d2",     bus.mul_data2_out,     e_d2);
`ifdef MUL_ARB_TIMEOUT_EN
    chk("cyc_err",    32'(bus.req_err),      32'(e_err));
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_vld[i]) begin
        vld_who.push_back(i);
        vld_edge.push_back(ecnt);
        vld_res.push_back(bus.req_result);
`ifdef MUL_ARB_TIMEOUT_EN
        err_log.push_back(bus.req_err);
`else
        err_log.push_back('0);
`endif
      end
    end
    if (bus.mul_trig_out) begin
      trg_edge.push_back(ecnt);
      trg_d1.push_back(bus.mul_data1_out);
      trg_d2.push_back(bus.mul_data2_out);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    vld_who.delete(); vld_edge.delete(); vld_res.delete(); err_log.delete();
    trg_edge.delete(); trg_d1.delete(); trg_d2.delete();
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_data1[32*i +: 32] = a;
    bus.req_data2[32*i +: 32] = b;
  endtask

  task automatic pulse(input logic [NREQ-1:0] m, output int t0);
    @(negedge sys_clk);
    bus.req_trig = m;
    t0 = ecnt + 1;
    @(negedge sys_clk);
    bus.req_trig = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge sys_clk);
    while (bus.req_busy != '0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles, want idle", name, budget);
    end
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n    = 1'b0;
    bus.req_trig = '0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  logic [31:0] exp_res2 [3];
  int t0, n;

  initial begin
    exp_res2[0] = 32'h40C00000;
    exp_res2[1] = 32'h40800000;
    exp_res2[2] = 32'h41100000;
    bus.req_trig  = '0;
    bus.req_data1 = '0;
    bus.req_data2 = '0;

    // reset state
    repeat (2) @(negedge sys_clk);
    chk("rst_busy",   32'(bus.req_busy),     32'd0);
    chk("rst_vld",    32'(bus.req_vld),      32'd0);
    chk("rst_result", bus.req_result,        32'd0);
    chk("rst_trig",   32'(bus.mul_trig_out), 32'd0);
    chk("rst_d1",     bus.mul_data1_out,     32'd0);
    chk("rst_d2",     bus.mul_data2_out,     32'd0);
    sys_rst_n = 1'b1;

    // single request
    clear_logs();
    set_ops(0, 32'h3FC00000, 32'h40000000);
    pulse(3'b001, t0);
    wait_idle("t1_idle", 40);
    chk("t1_trig_cnt", trg_edge.size(), 1);
    chk("t1_vld_cnt",  vld_who.size(),  1);
    if (trg_edge.size() >= 1) begin
      chk("t1_trig_lat", trg_edge[0] - t0, 2);
      chk("t1_d1", trg_d1[0], 32'h3FC00000);
      chk("t1_d2", trg_d2[0], 32'h40000000);
    end
    if (vld_who.size() >= 1 && trg_edge.size() >= 1) begin
      chk("t1_who", vld_who[0], 0);
      chk("t1_res", vld_res[0], 32'h40400000);
      chk("t1_vld_lat", vld_edge[0] - trg_edge[0], 4);
    end

    // contention from reset: 0, 1, 2
    do_reset();
    clear_logs();
    set_ops(0, 32'h40000000, 32'h40400000);
    set_ops(1, 32'h3F800000, 32'h40800000);
    set_ops(2, 32'h40400000, 32'h40400000);
    pulse(3'b111, t0);
    wait_idle("t2_idle", 100);
    chk("t2_trig_cnt", trg_edge.size(), 3);
    chk("t2_vld_cnt",  vld_who.size(),  3);
    for (int k = 0; k < 3 && k < vld_who.size(); k++) begin
      chk("t2_who", vld_who[k], k);
      chk("t2_res", vld_res[k], exp_res2[k]);
    end

    // fairness: 0 and 2 re-trig every cycle
    do_reset();
    clear_logs();
    set_ops(0, 32'h3FC00000, 32'h40000000);
    set_ops(2, 32'h40000000, 32'h40400000);
    @(negedge sys_clk);
    bus.req_trig = 3'b101;
    n = 0;
    while (vld_who.size() < 4 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    bus.req_trig = '0;
    wait_idle("t3_idle", 60);
    chk("t3_enough", 32'(vld_who.size() >= 4), 32'd1);
    for (int k = 0; k < 4 && k < vld_who.size(); k++) begin
      chk("t3_who", vld_who[k], (k % 2 == 1) ? 2 : 0);
      chk("t3_res", vld_res[k], (k % 2 == 1) ? 32'h40C00000 : 32'h40400000);
    end

    // busy drop on requester 1
    clear_logs();
    set_ops(1, 32'h3F800000, 32'h40800000);
    pulse(3'b010, t0);
    set_ops(1, 32'h40400000, 32'h40400000);
    @(negedge sys_clk);
    chk("t4_busy", 32'(bus.req_busy[1]), 32'd1);
    bus.req_trig = 3'b010;
    @(negedge sys_clk);
    bus.req_trig = '0;
    wait_idle("t4_idle", 40);
    repeat (4) @(negedge sys_clk);
    chk("t4_trig_cnt", trg_edge.size(), 1);
    chk("t4_vld_cnt",  vld_who.size(),  1);
    if (trg_edge.size() >= 1) begin
      chk("t4_d1", trg_d1[0], 32'h3F800000);
      chk("t4_d2", trg_d2[0], 32'h40800000);
    end
    if (vld_who.size() >= 1) begin
      chk("t4_who", vld_who[0], 1);
      chk("t4_res", vld_res[0], 32'h40800000);
    end

    // reset during WAIT
    clear_logs();
    set_ops(0, 32'h3FC00000, 32'h40000000);
    pulse(3'b001, t0);
    n = 0;
    while (trg_edge.size() == 0 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk("t5_reached_wait", trg_edge.size(), 1);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    chk("t5_rst_vld",    32'(bus.req_vld),      32'd0);
    chk("t5_rst_busy",   32'(bus.req_busy),     32'd0);
    chk("t5_rst_result", bus.req_result,        32'd0);
    chk("t5_rst_trig",   32'(bus.mul_trig_out), 32'd0);
    chk("t5_rst_d1",     bus.mul_data1_out,     32'd0);
    sys_rst_n = 1'b1;
    repeat (6) @(negedge sys_clk);
    inj_vld = 1'b1;
    inj_res = 32'h12345678;
    @(negedge sys_clk);
    inj_vld = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("t5_no_vld", vld_who.size(), 0);

`ifdef MUL_ARB_TIMEOUT_EN
    // watchdog: MultiUnit silent
    do_reset();
    clear_logs();
    mu_en = 1'b0;
    set_ops(0, 32'h3FC00000, 32'h40000000);
    pulse(3'b001, t0);
    wait_idle("t6_idle", 60);
    mu_en = 1'b1;
    chk("t6_vld_cnt", vld_who.size(), 1);
    if (vld_who.size() >= 1 && trg_edge.size() >= 1) begin
      chk("t6_who", vld_who[0], 0);
      chk("t6_res", vld_res[0], 32'h7FC00000);
      chk("t6_err", 32'(err_log[0]), 32'd1);
      chk("t6_lat", vld_edge[0] - trg_edge[0], TMO);
    end
    @(negedge sys_clk);
    inj_vld = 1'b1;
    inj_res = 32'h3F800000;
    @(negedge sys_clk);
    inj_vld = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("t6_late_ignored", vld_who.size(), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_unit_arbiter.md
Name: mul_unit_arbiter

Overview:
- Shares the single IEEE-754 multiplier unit (MultiUnit) among NUM_REQ requesting ALU operation blocks (e.g. Multi, Div, Sqrt).
- Each requester issues a one-cycle trig with two operands. The arbiter latches the operands and picks a requester round-robin.
- It drives the MultiUnit trig/operand interface, waits for the MultiUnit result, and returns the result to the granted requester.
- It sits between the operation blocks and MultiUnit at the ALU top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GRANT_W, $clog2(NUM_REQ), width of the grant index (derived; not overridden).
- TIMEOUT_CYC, 64, watchdog limit in cycles. Used only with MUL_ARB_TIMEOUT_EN.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- req_trig  in  NUM_REQ  one-cycle request pulse per requester
- req_data1  in  NUM_REQ*32  operand 1 per requester; slot i = bits [32i+31:32i]
- req_data2  in  NUM_REQ*32  operand 2 per requester, same packing as req_data1
- req_result  out  32  result, shared by all requesters; valid when that requester's req_vld is high
- req_vld  out  NUM_REQ  one-cycle completion pulse per requester
- req_busy  out  NUM_REQ  high while that requester's request is pending
- mul_data1_out  out  32  MultiUnit operand 1
- mul_data2_out  out  32  MultiUnit operand 2
- mul_trig_out  out  1  MultiUnit start pulse
- mul_result_in  in  32  MultiUnit result
- mul_result_vld  in  1  MultiUnit result-valid pulse

Behaviour:
- Clock and reset: one clock, sys_clk; reset sys_rst_n is asynchronous, active-low. All outputs are registered.
- Reset values:
  - All outputs are 0.
  - pending, slot operands and grant are cleared.
  - last_grant = NUM_REQ-1, so requester 0 wins the first arbitration.
  - state = IDLE.
- Request capture:
  - On an edge where req_trig[i]=1 and pending[i]=0: latch operands into slot i and set pending[i].
  - req_trig[i] while pending[i]=1 is dropped silently.
  - req_busy = pending.
- FSM IDLE: if any pending bit is set, select the first set bit searching from last_grant+1 upward with wrap. Store it as grant, then go to ISSUE.
- FSM ISSUE:
  - mul_data1_out and mul_data2_out load slot[grant].
  - mul_trig_out = 1 for exactly one cycle.
  - Next state is WAIT.
- FSM WAIT:
  - mul_data outputs hold their values.
  - On mul_result_vld: req_result <= mul_result_in, req_vld[grant] pulses for one cycle, pending[grant] clears, last_grant <= grant, state <= IDLE.
- mul_result_vld seen in IDLE or ISSUE is ignored.
- Latency (no contention):
  - req_trig sampled at edge E0 → mul_trig_out high in the cycle after edge E2.
  - mul_result_vld sampled at edge Ek → req_vld high in the cycle after edge Ek.
- Turnaround: back-to-back grants have one IDLE cycle between a completion and the next ISSUE.
- Re-request timing: a requester may re-trig in the cycle its req_vld is high. pending clears at that same edge, so the new trig is captured at the next edge.
- Simultaneous trig and completion for the same requester on one edge: the trig is dropped, because pending is still 1 when sampled.
- Reset mid-operation:
  - All pending requests are discarded; no req_vld is produced.
  - A MultiUnit result arriving after reset is released is ignored, because the FSM is in IDLE.
- req_result holds its last value between completions.

Optional Feature:
- Macro MUL_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYC cycles pass without mul_result_vld, the arbiter completes the request with req_result = 32'h7FC00000 (quiet NaN).
  - It pulses req_vld[grant] together with extra output req_err[grant] (NUM_REQ bits, reset 0) and returns to IDLE.
  - A late mul_result_vld is then ignored.
- When undefined: no req_err port and no counter; WAIT waits indefinitely.

Decomposition:
- Shared package alu_pkg holds:
  - FSM state enum (IDLE, ISSUE, WAIT);
  - FP_QNAN = 32'h7FC00000;
  - operand width constant 32.
- One sub-module, rr_arbiter: inputs pending and last_grant, output next grant index plus any-valid flag. It is purely combinational.

Test Plan:
- Single request: trig requester 0 with 32'h3FC00000 × 32'h40000000.
  - mul_trig_out pulses 2 cycles later with those operands.
  - MultiUnit model returns 32'h40400000 three cycles later; req_vld[0] pulses with req_result = 32'h40400000.
- Contention: trig requesters 0, 1 and 2 in the same cycle → grants in order 0, 1, 2, each with the correct result. There is never more than one mul_trig_out pulse outstanding.
- Round-robin fairness: requesters 0 and 2 re-trig continuously → grants alternate 0, 2, 0, 2.
- Busy drop: re-trig requester 1 with new operands while req_busy[1]=1 → the second trig is ignored; the original operands reach the MultiUnit and only one req_vld[1] pulse occurs.
- Reset mid-operation: assert sys_rst_n=0 during WAIT → all outputs are 0; a subsequent mul_result_vld produces no req_vld.
- With MUL_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: the MultiUnit model never responds → after 8 WAIT cycles req_vld[0], req_err[0] and req_result = 32'h7FC00000; the FSM returns to IDLE.
